serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first,
// one bit per clock, with a start/busy/done handshake.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input. When sub=1 the
// block computes a - b as a + ~b + 1.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic             cy;
   logic [CW-1:0]    cnt;

   logic             last_bit;
   logic             s_bit;
   logic             cy_next;
   logic [WIDTH-1:0] ld_b;
   logic             ld_cy;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // Next-state logic plus the full-adder cell and the operand-load muxing
   always_comb begin
      state_next = state;
      last_bit   = (cnt == CW'(WIDTH - 1));
      s_bit      = sh_a[0] ^ sh_b[0] ^ cy;
      cy_next    = (sh_a[0] & sh_b[0]) | (sh_a[0] & cy) | (sh_b[0] & cy);
`ifdef SERIAL_ADDER_SUB_EN
      ld_b       = sub ? ~b : b;
      ld_cy      = sub ? 1'b1 : c;
`else
      ld_b       = b;
      ld_cy      = c;
`endif
      case (state)
         S_IDLE:  if (start) state_next = S_ADD;
         S_ADD:   if (last_bit) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake outputs, registered from the next state so they track the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == S_ADD);
         done <= (state_next == S_DONE);
      end
   end

   // Operand capture, bit-serial shifting and result update on the final bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         cy    <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sh_a <= a;
                  sh_b <= ld_b;
                  cy   <= ld_cy;
                  cnt  <= '0;
               end
            end
            S_ADD: begin
               sh_a <= {1'b0, sh_a[WIDTH-1:1]};
               sh_b <= {1'b0, sh_b[WIDTH-1:1]};
               res  <= {s_bit, res[WIDTH-1:1]};
               cy   <= cy_next;
               cnt  <= cnt + CW'(1);
               if (last_bit) begin
                  sum   <= {s_bit, res[WIDTH-1:1]};
                  carry <= cy_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). It compares the DUT against
// the arithmetic reference {carry,sum} = a + b + c. In builds with
// SERIAL_ADDER_SUB_EN it also checks a - b.
module tb_serial_adder;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   int               n_vec;
   int               n_err;
   logic [WIDTH:0]   last_res;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .c     (c),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, modulo 2^(WIDTH+1)
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic ci, input logic s);
      longint r;
      if (s) r = longint'(x) + ((longint'(1) << WIDTH) - 1 - longint'(y)) + 1;
      else   r = longint'(x) + longint'(y) + longint'(ci);
      return (WIDTH+1)'(r);
   endfunction

   // One full operation with exact latency checking
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts, input string name);
      logic [WIDTH:0] exp;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_; c = tc; sub = ts;
      exp = ref_add(a, b, c, sub);
      @(posedge clk);
      #1;
      start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
      for (int i = 0; i < int'(WIDTH); i++) begin
         @(negedge clk);
         n_vec++;
         if (busy !== 1'b1 || done !== 1'b0 || {carry, sum} !== last_res) begin
            n_err++;
            $display("FAIL %s add_cycle%0d busy=%b done=%b res=%h, need busy=1 done=0 res=%h",
                     name, i, busy, done, {carry, sum}, last_res);
         end
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_pulse done=%b busy=%b, need done=1 busy=0", name, done, busy);
      end
      n_vec++;
      if ({carry, sum} !== exp) begin
         n_err++;
         $display("FAIL %s result got=%h need=%h", name, {carry, sum}, exp);
      end
      last_res = exp;
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s back_to_idle done=%b busy=%b, need 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = '1; b = '1; c = 1'b1;
      last_res = '0;
      #1;
      n_vec++;
      if ({busy, done, carry, sum} !== '0) begin
         n_err++;
         $display("FAIL reset_async got=%h need=0", {busy, done, carry, sum});
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({busy, done, carry, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_hold%0d got=%h need=0", i, {busy, done, carry, sum});
         end
      end
      start = 1'b0;
      rst_n = 1'b1;
      run_op(8'h00, 8'h00, 1'b0, 1'b0, "zero");
   endtask

   task automatic test_directed;
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, "ff_plus_01");
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_plus_5a_c");
      run_op(8'h3C, 8'h42, 1'b0, 1'b0, "3c_plus_42");
   endtask

   task automatic test_hold;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++;
         if (sum !== 8'h7E || carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL hold%0d sum=%h carry=%b busy=%b done=%b, need 7e 0 0 0",
                     i, sum, carry, busy, done);
         end
      end
   endtask

   task automatic test_ignore_start;
      logic [WIDTH:0] exp;
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h01; c = 1'b0; sub = 1'b0;
      exp = ref_add(a, b, c, sub);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         @(negedge clk);
         n_vec++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore add_cycle%0d busy=%b done=%b, need 1 0", i, busy, done);
         end
         if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
         if (i == 3) start = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b1 || {carry, sum} !== exp) begin
         n_err++;
         $display("FAIL ignore result done=%b got=%h, need done=1 res=%h", done, {carry, sum}, exp);
      end
      last_res = exp;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore no_queue%0d busy=%b done=%b, need 0 0", i, busy, done);
         end
      end
   endtask

   task automatic test_reset_abort;
      @(negedge clk);
      start = 1'b1; a = 8'h0F; b = 8'h01; c = 1'b0; sub = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      rst_n = 1'b0;
      last_res = '0;
      #1;
      n_vec++;
      if ({busy, done, carry, sum} !== '0) begin
         n_err++;
         $display("FAIL abort_reset got=%h need=0", {busy, done, carry, sum});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < int'(WIDTH) + 4; i++) begin
         @(negedge clk);
         n_vec++;
         if ({busy, done, carry, sum} !== '0) begin
            n_err++;
            $display("FAIL abort_idle%0d got=%h need=0", i, {busy, done, carry, sum});
         end
      end
   endtask

   task automatic test_random;
      for (int k = 0; k < 40; k++)
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, "random");
   endtask

   // start held high: WIDTH+1 cycles to return to IDLE plus one IDLE cycle per accept
   task automatic test_back_to_back;
      logic [WIDTH-1:0] xa [4];
      logic [WIDTH-1:0] xb [4];
      logic             xc [4];
      logic [WIDTH:0]   exp;
      int               t;
      int               last_t;
      bit               seen;
      for (int k = 0; k < 4; k++) begin
         xa[k] = WIDTH'($urandom); xb[k] = WIDTH'($urandom); xc[k] = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b1; a = xa[0]; b = xb[0]; c = xc[0]; sub = 1'b0;
      t = 0; last_t = 0;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 3 * int'(WIDTH) && !seen; i++) begin
            @(negedge clk);
            t++;
            if (done === 1'b1) seen = 1'b1;
         end
         n_vec++;
         if (!seen) begin
            n_err++;
            $display("FAIL b2b%0d timeout done=%b, need a done pulse", k, done);
         end else begin
            exp = ref_add(xa[k], xb[k], xc[k], sub);
            n_vec++;
            if ({carry, sum} !== exp) begin
               n_err++;
               $display("FAIL b2b%0d result got=%h need=%h", k, {carry, sum}, exp);
            end
            last_res = exp;
            if (k > 0) begin
               n_vec++;
               if (t - last_t != int'(WIDTH) + 2) begin
                  n_err++;
                  $display("FAIL b2b%0d spacing got=%0d need=%0d", k, t - last_t, WIDTH + 2);
               end
            end
            last_t = t;
         end
         if (k < 3) begin a = xa[k+1]; b = xb[k+1]; c = xc[k+1]; end
         else start = 1'b0;
      end
      repeat (WIDTH + 3) @(negedge clk);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub;
      run_op(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
      run_op(8'h01, 8'h02, 1'b1, 1'b1, "sub_01_02");
      for (int k = 0; k < 10; k++)
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), "sub_random");
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_directed();
      test_hold();
      test_ignore_start();
      test_reset_abort();
      test_random();
      test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
